// File: rtl/kb_code_decoder_pkg.sv
// Shared constants and types for the PS/2 Set-2 scan-code decoder path.
// Imported by the decoder top and its event FIFO.
package kb_code_decoder_pkg;

   localparam logic [7:0] KB_EXT    = 8'hE0;
   localparam logic [7:0] KB_BRK    = 8'hF0;
   localparam logic [7:0] KB_PAUSE  = 8'hE1;
   localparam logic [7:0] KB_ERR0   = 8'h00;
   localparam logic [7:0] KB_ERR1   = 8'hFF;
   localparam logic [7:0] KB_LSHIFT = 8'h12;
   localparam logic [7:0] KB_RSHIFT = 8'h59;
   localparam logic [7:0] KB_CTRL   = 8'h14;

   localparam int unsigned KB_EVW = 10;

   // Pause is E1 followed by seven more bytes.
   localparam logic [2:0] KB_PAUSE_SKIP = 3'd7;

   typedef enum logic [2:0] {
      StIdle,
      StExt,
      StBrk,
      StExtBrk,
      StPause
   } kb_state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } kb_event_t;

endpackage

// File: rtl/kb_event_fifo.sv
// Generic synchronous first-word-fall-through FIFO with AW+1 bit pointers.
// Head data is combinational from storage and forced to zero while empty.
module kb_event_fifo #(
   parameter int unsigned DW = 10,
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr,
   input  logic [DW-1:0] din,
   input  logic          rd,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full
);

   localparam int unsigned Depth = 1 << AW;

   logic [DW-1:0] mem_q [Depth];
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic          do_wr, do_rd;

   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      // A read while full frees the slot the concurrent write lands in.
      do_wr = wr && (!full || rd);
      do_rd = rd && !empty;
      wptr_d = do_wr ? wptr_q + 1'b1 : wptr_q;
      rptr_d = do_rd ? rptr_q + 1'b1 : rptr_q;
      dout   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/kb_code_decoder.sv
// Turns raw Set-2 scan bytes into {ext, brk, code} key events, tracks Shift/Ctrl,
// and queues events in a small FWFT FIFO.
module kb_code_decoder
   import kb_code_decoder_pkg::*;
#(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       rd,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       empty,
   output logic       full,
   output logic       overflow_tick,
   output logic       shift_on,
   output logic       ctrl_on
);

   kb_state_e  state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       lshift_q, lshift_d;
   logic       rshift_q, rshift_d;
   logic       ctrl_q, ctrl_d;
   logic       ovf_q, ovf_d;
   logic       emit;
   kb_event_t  ev;
   kb_event_t  head;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      emit     = 1'b0;
      ev       = '0;
      if (rx_done_tick) begin
         if (rx_data == KB_ERR0 || rx_data == KB_ERR1) begin
            state_d = StIdle;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (rx_data == KB_EXT) begin
                     state_d = StExt;
                  end else if (rx_data == KB_BRK) begin
                     state_d = StBrk;
                  end else if (rx_data == KB_PAUSE) begin
                     state_d = StPause;
                     cnt_d   = KB_PAUSE_SKIP;
                  end else begin
                     emit = 1'b1;
                     ev   = '{ext: 1'b0, brk: 1'b0, code: rx_data};
                  end
               end
               StExt: begin
                  if (rx_data == KB_BRK) begin
                     state_d = StExtBrk;
                  end else if (rx_data != KB_EXT) begin
                     emit    = 1'b1;
                     ev      = '{ext: 1'b1, brk: 1'b0, code: rx_data};
                     state_d = StIdle;
                  end
               end
               StBrk: begin
                  // F0 E0 is out of order but still treated as an extended break.
                  if (rx_data == KB_EXT) begin
                     state_d = StExtBrk;
                  end else if (rx_data != KB_BRK) begin
                     emit    = 1'b1;
                     ev      = '{ext: 1'b0, brk: 1'b1, code: rx_data};
                     state_d = StIdle;
                  end
               end
               StExtBrk: begin
                  if (rx_data != KB_EXT && rx_data != KB_BRK) begin
                     emit    = 1'b1;
                     ev      = '{ext: 1'b1, brk: 1'b1, code: rx_data};
                     state_d = StIdle;
                  end
               end
               StPause: begin
                  cnt_d = cnt_q - 3'd1;
                  if (cnt_q == 3'd1) begin
                     emit    = 1'b1;
                     ev      = '{ext: 1'b1, brk: 1'b0, code: KB_PAUSE};
                     state_d = StIdle;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   // Modifiers follow every emitted event, whether or not the FIFO keeps it.
   always_comb begin
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      ctrl_d   = ctrl_q;
      if (emit) begin
         if (!ev.ext && ev.code == KB_LSHIFT) lshift_d = !ev.brk;
         if (!ev.ext && ev.code == KB_RSHIFT) rshift_d = !ev.brk;
         if (ev.code == KB_CTRL)              ctrl_d   = !ev.brk;
      end
      ovf_d = emit && full && !rd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         ctrl_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lshift_q <= lshift_d;
         rshift_q <= rshift_d;
         ctrl_q   <= ctrl_d;
         ovf_q    <= ovf_d;
      end
   end

   kb_event_fifo #(
      .DW (KB_EVW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (emit),
      .din   (ev),
      .rd    (rd),
      .dout  (head),
      .empty (empty),
      .full  (full)
   );

   assign key_code      = head.code;
   assign key_ext       = head.ext;
   assign key_break     = head.brk;
   assign overflow_tick = ovf_q;
   assign shift_on      = lshift_q | rshift_q;
   assign ctrl_on       = ctrl_q;

endmodule
